// File: rtl/xyolo_mac_vect.sv
// Vector MAC stage: one shared pixel times N_LANES weights, per-lane accumulate/shift/saturate.
// Optional LeakyReLU-style activation on config register 5 under `XYOLO_MAC_LEAKY_EN.
module xyolo_mac_lane #(
  parameter int DW = 16,
  parameter int AW = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld1,
  input  logic                 ld2,
  input  logic                 ld3,
  input  logic                 first,
  input  logic signed [DW-1:0] pixel,
  input  logic signed [DW-1:0] weight,
  input  logic signed [DW-1:0] bias,
  input  logic [5:0]           shift,
  input  logic [5:0]           bshift,
  input  logic                 leaky,
  output logic [DW-1:0]        out
);
  logic signed [2*DW-1:0] prod_q, prod_d;
  logic signed [DW-1:0]   bias_q, bias_d;
  logic signed [AW-1:0]   acc_q, acc_d, prod_x, bias_x, shv;
  logic [DW-1:0]          out_q, out_d;

  always_comb begin
    prod_d = ld1 ? pixel * weight : prod_q;
    bias_d = ld1 ? bias : bias_q;
    prod_x = {{(AW-2*DW){prod_q[2*DW-1]}}, prod_q};
    bias_x = {{(AW-DW){bias_q[DW-1]}}, bias_q};
    acc_d  = acc_q;
    if (ld2) acc_d = first ? (bias_x <<< bshift) + prod_x : acc_q + prod_x;
    shv = acc_q >>> shift;
    if (leaky && shv[AW-1]) shv = shv >>> 3;
    out_d = out_q;
    // in range when every bit above the result sign agrees with it
    if (ld3) begin
      if (&shv[AW-1:DW-1] || ~|shv[AW-1:DW-1]) out_d = shv[DW-1:0];
      else out_d = shv[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0; bias_q <= '0; acc_q <= '0; out_q <= '0;
    end else begin
      prod_q <= prod_d; bias_q <= bias_d; acc_q <= acc_d; out_q <= out_d;
    end
  end

  assign out = out_q;
endmodule

module xyolo_mac_vect #(
  parameter int N_LANES    = 4,
  parameter int DATAPATH_W = 16,
  parameter int ACC_W      = 40,
  parameter int CNT_W      = 12,
  parameter int ADDR_W     = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          run,
  output logic                          done,
  input  logic                          valid,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [31:0]                   wdata,
  input  logic                          wstrb,
  input  logic [DATAPATH_W-1:0]         flow_in_pixel,
  input  logic [N_LANES*DATAPATH_W-1:0] flow_in_weight,
  input  logic [N_LANES*DATAPATH_W-1:0] flow_in_bias,
  output logic [N_LANES*DATAPATH_W-1:0] flow_out,
  output logic                          flow_out_valid
);
  typedef enum logic [1:0] {IDLE, WAIT, ACC, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d, per_q, per_d, delay_q, delay_d;
  logic [5:0]       shift_q, shift_d, bshift_q, bshift_d;
  logic [CNT_W-1:0] s_iter_q, s_per_q, s_delay_q;
  logic [5:0]       s_shift_q, s_bshift_q;
  logic [CNT_W-1:0] dly_q, dly_d, pcnt_q, pcnt_d, icnt_q, icnt_d;
  logic [3:1]       vld_pipe_q, vld_pipe_d;
  logic             first1_q, last1_q, last2_q;
  logic             vin, first, last, flush, leaky_act;
  logic             unused_wdata;

  assign unused_wdata = ^wdata[31:CNT_W];

`ifdef XYOLO_MAC_LEAKY_EN
  logic leaky_q, leaky_d, s_leaky_q;
  assign leaky_act = s_leaky_q;
`else
  assign leaky_act = 1'b0;
`endif

  always_comb begin
    iter_d = iter_q; per_d = per_q; delay_d = delay_q;
    shift_d = shift_q; bshift_d = bshift_q;
`ifdef XYOLO_MAC_LEAKY_EN
    leaky_d = leaky_q;
`endif
    if (clear) begin
      iter_d = '0; per_d = '0; delay_d = '0; shift_d = '0; bshift_d = '0;
`ifdef XYOLO_MAC_LEAKY_EN
      leaky_d = 1'b0;
`endif
    end else if (valid && wstrb) begin
      case (addr)
        ADDR_W'(0): iter_d   = wdata[CNT_W-1:0];
        ADDR_W'(1): per_d    = wdata[CNT_W-1:0];
        ADDR_W'(2): delay_d  = wdata[CNT_W-1:0];
        ADDR_W'(3): shift_d  = wdata[5:0];
        ADDR_W'(4): bshift_d = wdata[5:0];
`ifdef XYOLO_MAC_LEAKY_EN
        ADDR_W'(5): leaky_d  = wdata[0];
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter_q <= '0; per_q <= '0; delay_q <= '0; shift_q <= '0; bshift_q <= '0;
      s_iter_q <= '0; s_per_q <= '0; s_delay_q <= '0; s_shift_q <= '0; s_bshift_q <= '0;
`ifdef XYOLO_MAC_LEAKY_EN
      leaky_q <= 1'b0; s_leaky_q <= 1'b0;
`endif
    end else begin
      iter_q <= iter_d; per_q <= per_d; delay_q <= delay_d;
      shift_q <= shift_d; bshift_q <= bshift_d;
`ifdef XYOLO_MAC_LEAKY_EN
      leaky_q <= leaky_d;
      if (run) s_leaky_q <= leaky_q;
`endif
      if (run) begin
        s_iter_q <= iter_q; s_per_q <= per_q; s_delay_q <= delay_q;
        s_shift_q <= shift_q; s_bshift_q <= bshift_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // dly_q doubles as the delay countdown in WAIT and the drain counter in DRAIN
  always_comb begin
    state_d = state_q; dly_d = dly_q; pcnt_d = pcnt_q; icnt_d = icnt_q;
    vin = 1'b0; first = 1'b0; last = 1'b0; flush = 1'b0;
    if (run) begin
      flush  = (state_q != IDLE);
      pcnt_d = '0; icnt_d = '0; dly_d = delay_q;
      if (iter_q == '0 || per_q == '0) state_d = IDLE;
      else if (delay_q == '0)          state_d = ACC;
      else                             state_d = WAIT;
    end else begin
      case (state_q)
        WAIT: begin
          dly_d = dly_q - CNT_W'(1);
          if (dly_q == CNT_W'(1)) state_d = ACC;
        end
        ACC: begin
          vin   = 1'b1;
          first = (pcnt_q == '0);
          last  = (pcnt_q == s_per_q - CNT_W'(1));
          pcnt_d = last ? '0 : pcnt_q + CNT_W'(1);
          if (last) begin
            if (icnt_q == s_iter_q - CNT_W'(1)) begin
              state_d = DRAIN; dly_d = '0;
            end else icnt_d = icnt_q + CNT_W'(1);
          end
        end
        DRAIN: begin
          dly_d = dly_q + CNT_W'(1);
          if (dly_q == CNT_W'(1)) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done = (state_q == IDLE);
  end

  always_comb begin
    vld_pipe_d = flush ? '0 : {vld_pipe_q[2] & last2_q, vld_pipe_q[1], vin};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_q <= '0; pcnt_q <= '0; icnt_q <= '0;
      vld_pipe_q <= '0; first1_q <= 1'b0; last1_q <= 1'b0; last2_q <= 1'b0;
    end else begin
      dly_q <= dly_d; pcnt_q <= pcnt_d; icnt_q <= icnt_d;
      vld_pipe_q <= vld_pipe_d;
      first1_q <= first; last1_q <= last; last2_q <= last1_q;
    end
  end

  assign flow_out_valid = vld_pipe_q[3];

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    xyolo_mac_lane #(.DW(DATAPATH_W), .AW(ACC_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .ld1    (vin),
      .ld2    (vld_pipe_q[1]),
      .ld3    (vld_pipe_q[2] & last2_q & ~flush),
      .first  (first1_q),
      .pixel  (flow_in_pixel),
      .weight (flow_in_weight[(N_LANES-1-i)*DATAPATH_W +: DATAPATH_W]),
      .bias   (flow_in_bias[(N_LANES-1-i)*DATAPATH_W +: DATAPATH_W]),
      .shift  (s_shift_q),
      .bshift (s_bshift_q),
      .leaky  (leaky_act),
      .out    (flow_out[(N_LANES-1-i)*DATAPATH_W +: DATAPATH_W])
    );
  end
endmodule

// File: tb/tb_xyolo_mac_vect.sv
// Directed bench for xyolo_mac_vect: arithmetic model of each run plus per-cycle strobe compare.
module tb_xyolo_mac_vect;
  logic        clk = 0, rst = 0, clear = 0, run = 0, valid = 0, wstrb = 0;
  logic [2:0]  addr = 0;
  logic [31:0] wdata = 0;
  logic [15:0] flow_in_pixel = 16'h5A5A;
  logic [63:0] flow_in_weight = {4{16'h1357}}, flow_in_bias = {4{16'h2468}};
  logic [63:0] flow_out;
  logic        done, flow_out_valid;

  xyolo_mac_vect dut (
    .clk(clk), .rst(rst), .clear(clear), .run(run), .done(done),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .flow_in_pixel(flow_in_pixel), .flow_in_weight(flow_in_weight),
    .flow_in_bias(flow_in_bias), .flow_out(flow_out), .flow_out_valid(flow_out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  typedef struct { int c; logic [63:0] v; } exp_t;
  exp_t expq[$];
  int cfg[6];
  logic signed [15:0] pix[64];
  logic signed [15:0] wt[64][4];
  logic signed [15:0] bs[64][4];
  int op_base = 1 << 30, op_n = 0, drv_j;

  // operand j is presented during cycle op_base+j
  always @(posedge clk) begin
    #2;
    drv_j = cyc - op_base;
    if (drv_j >= 0 && drv_j < op_n) begin
      flow_in_pixel = pix[drv_j];
      for (int l = 0; l < 4; l++) begin
        flow_in_weight[(3-l)*16 +: 16] = wt[drv_j][l];
        flow_in_bias[(3-l)*16 +: 16]   = bs[drv_j][l];
      end
    end else begin
      flow_in_pixel = 16'h5A5A; flow_in_weight = {4{16'h1357}}; flow_in_bias = {4{16'h2468}};
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (expq.size() > 0 && expq[0].c == cyc) begin
        if (flow_out_valid !== 1'b1 || flow_out !== expq[0].v) begin
          errors++;
          $display("FAIL strobe cyc=%0d got valid=%b out=%h, want valid=1 out=%h",
                   cyc, flow_out_valid, flow_out, expq[0].v);
        end
        void'(expq.pop_front());
      end else if (flow_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL spurious_strobe cyc=%0d got valid=%b out=%h, want valid=0", cyc, flow_out_valid, flow_out);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  function automatic logic [63:0] model(input int b, input int per, input int sh, input int bsh, input int lk);
    logic [63:0] r;
    longint acc, v;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      acc = longint'(bs[b][l]) <<< bsh;
      acc = (acc <<< 24) >>> 24;
      for (int q = 0; q < per; q++) begin
        acc = acc + longint'(pix[b+q]) * longint'(wt[b+q][l]);
        acc = (acc <<< 24) >>> 24;
      end
      v = acc >>> sh;
      if (lk != 0 && v < 0) v = v >>> 3;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      r[(3-l)*16 +: 16] = v[15:0];
    end
    return r;
  endfunction

  task automatic cfg_write(input int a, input int d);
    valid = 1; wstrb = 1; addr = 3'(a); wdata = 32'(d);
    @(posedge clk); #1;
    valid = 0; wstrb = 0;
    case (a)
      0, 1, 2: cfg[a] = d & 12'hFFF;
      3, 4:    cfg[a] = d & 63;
`ifdef XYOLO_MAC_LEAKY_EN
      5:       cfg[a] = d & 1;
`endif
      default: ;
    endcase
  endtask

  task automatic cfg_all(input int it, input int pe, input int de, input int sh, input int bsh);
    cfg_write(0, it); cfg_write(1, pe); cfg_write(2, de); cfg_write(3, sh); cfg_write(4, bsh);
  endtask

  // run during cycle t; expectations come from the config as it stood at t
  task automatic start_run(output int t);
    int sc[6];
    sc = cfg;
    t = cyc;
    run = 1;
    expq.delete();
    if (sc[0] != 0 && sc[1] != 0) begin
      op_base = t + 1 + sc[2];
      op_n = sc[0] * sc[1];
      for (int p = 0; p < sc[0]; p++)
        expq.push_back('{c: op_base + p*sc[1] + sc[1] - 1 + 3,
                         v: model(p*sc[1], sc[1], sc[3], sc[4], sc[5])});
    end else op_n = 0;
    @(posedge clk); #1;
    run = 0;
  endtask

  task automatic set_op(input int j, input int p, input int w0, input int w1, input int w2, input int w3, input int b);
    pix[j] = 16'(p);
    wt[j][0] = 16'(w0); wt[j][1] = 16'(w1); wt[j][2] = 16'(w2); wt[j][3] = 16'(w3);
    for (int l = 0; l < 4; l++) bs[j][l] = 16'(b);
  endtask

  int t, t2;
  logic [63:0] lk_lit;

  initial begin
    for (int i = 0; i < 6; i++) cfg[i] = 0;
    #12;
    chk("reset_done", 64'(done), 64'd1);
    chk("reset_out", flow_out, 64'd0);
    chk("reset_valid", 64'(flow_out_valid), 64'd0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;

    // basic single-operand run
    set_op(0, 3, 2, -4, 5, 0, 1);
    cfg_all(1, 1, 0, 0, 0);
    start_run(t);
    chk("s1_done_falls", 64'(done), 64'd0);
    repeat (3) @(posedge clk); #1;
    chk("s1_out_lit", flow_out, {16'h0007, 16'hFFF5, 16'h0010, 16'h0001});
    chk("s1_valid", 64'(flow_out_valid), 64'd1);
    chk("s1_done", 64'(done), 64'd1);
    repeat (3) @(posedge clk); #1;

    // two periods of three with delay and shift; only the first bias of a period counts
    for (int j = 0; j < 6; j++) set_op(j, 1, 1, 1, 1, 1, (j % 3 == 0) ? 10 : 99);
    cfg_all(2, 3, 2, 1, 0);
    start_run(t);
    chk("s2_done_falls", 64'(done), 64'd0);
    repeat (7) @(posedge clk); #1;
    chk("s2_out1_lit", flow_out, {4{16'd6}});
    chk("s2_valid1", 64'(flow_out_valid), 64'd1);
    repeat (3) @(posedge clk); #1;
    chk("s2_out2_lit", flow_out, {4{16'd6}});
    chk("s2_done", 64'(done), 64'd1);
    repeat (3) @(posedge clk); #1;

    // saturation both ways
    for (int j = 0; j < 4; j++) set_op(j, 32'h7FFF, 32'h7FFF, 32'h7FFF, -32'sh7FFF, -32'sh7FFF, 0);
    cfg_all(1, 4, 0, 0, 0);
    start_run(t);
    repeat (6) @(posedge clk); #1;
    chk("s3_sat_lit", flow_out, {16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000});
    repeat (3) @(posedge clk); #1;

    // ITER rewritten mid-run only affects the next run; then clear
    set_op(0, 2, 1, -2, 3, 7, 5); set_op(1, 3, 4, 4, -1, 0, 0);
    set_op(2, -1, 2, 2, 2, 2, -6); set_op(3, 4, -3, 1, 0, 9, 0);
    cfg_all(1, 2, 0, 0, 0);
    start_run(t);
    cfg_write(0, 2);
    repeat (7) @(posedge clk); #1;
    chk("s4_done_old_iter", 64'(done), 64'd1);
    start_run(t);
    repeat (10) @(posedge clk); #1;
    chk("s4_done_new_iter", 64'(done), 64'd1);
    clear = 1; @(posedge clk); #1; clear = 0;
    for (int i = 0; i < 6; i++) cfg[i] = 0;
    start_run(t);
    chk("s4_clear_done", 64'(done), 64'd1);
    repeat (6) @(posedge clk); #1;
    chk("s4_clear_done_late", 64'(done), 64'd1);

    // abort mid-ACC, restart with PER=1 picked up from a write made during the aborted run
    set_op(0, 3, 2, -4, 5, 0, 1);
    for (int j = 1; j < 4; j++) set_op(j, 100, 100, 100, 100, 100, 0);
    cfg_all(1, 4, 0, 0, 0);
    start_run(t);
    repeat (2) @(posedge clk); #1;
    cfg_write(1, 1);
    start_run(t2);
    chk("s5_restart_busy", 64'(done), 64'd0);
    repeat (3) @(posedge clk); #1;
    chk("s5_restart_lit", flow_out, {16'h0007, 16'hFFF5, 16'h0010, 16'h0001});
    chk("s5_restart_done", 64'(done), 64'd1);
    repeat (3) @(posedge clk); #1;

    // asynchronous reset mid-run
    set_op(1, 1, 1, 1, 1, 1, 2);
    cfg_all(2, 1, 0, 0, 0);
    start_run(t);
    repeat (3) @(posedge clk); #1;
    @(negedge clk); #1;
    rst = 0; #1;
    expq.delete();
    for (int i = 0; i < 6; i++) cfg[i] = 0;
    chk("s5_rst_done", 64'(done), 64'd1);
    chk("s5_rst_out", flow_out, 64'd0);
    chk("s5_rst_valid", 64'(flow_out_valid), 64'd0);
    #1 rst = 1;
    @(posedge clk); #1;

    // activation register (no effect unless the option is built in)
    set_op(0, -8, 10, -10, 10, 10, 0);
    cfg_all(1, 1, 0, 0, 0);
    cfg_write(5, 1);
    start_run(t);
    repeat (3) @(posedge clk); #1;
`ifdef XYOLO_MAC_LEAKY_EN
    lk_lit = {16'hFFF6, 16'h0050, 16'hFFF6, 16'hFFF6};
`else
    lk_lit = {16'hFFB0, 16'h0050, 16'hFFB0, 16'hFFB0};
`endif
    chk("s6_leaky_lit", flow_out, lk_lit);
    repeat (3) @(posedge clk); #1;

    // bias shift
    set_op(0, 0, 0, 0, 0, 0, 0);
    bs[0][0] = -16'sd3; bs[0][1] = 16'sd5; bs[0][2] = 16'sh7FFF; bs[0][3] = 16'sd1;
    cfg_write(5, 0);
    cfg_write(4, 4);
    start_run(t);
    repeat (3) @(posedge clk); #1;
    chk("s7_bshift_lit", flow_out, {16'hFFD0, 16'h0050, 16'h7FFF, 16'h0010});
    repeat (4) @(posedge clk); #1;

    chk("pending_expectations", 64'(expq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
